// File: rtl/btn_event_queue.sv
// Press-event queue: rising edges of debounced buttons are serialised lowest
// index first into a small FIFO read through a valid/ready handshake.
module btn_event_queue #(
   parameter  int N_BTN  = 4,
   parameter  int DEPTH  = 4,
   localparam int CODE_W = $clog2(N_BTN),
   localparam int LVL_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_BTN-1:0]  btn_i,
   input  logic              clr_ovf_i,
   output logic              evt_valid_o,
   output logic [CODE_W-1:0] evt_code_o,
   input  logic              evt_ready_i,
   output logic [LVL_W-1:0]  level_o,
   output logic              overflow_o,
   output logic [N_BTN-1:0]  last_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(DEPTH);

   typedef enum logic [0:0] {ST_ARM = 1'b0, ST_RUN = 1'b1} state_t;

   function automatic logic [CODE_W-1:0] lowest_idx(input logic [N_BTN-1:0] v);
      lowest_idx = '0;
      for (int i = N_BTN - 1; i >= 0; i--) begin
         if (v[i]) begin
            lowest_idx = CODE_W'(i);
         end
      end
   endfunction

   function automatic logic [N_BTN-1:0] one_hot(input logic [CODE_W-1:0] code);
      one_hot = '0;
      one_hot[code] = 1'b1;
   endfunction

   state_t              state_r;
   logic [N_BTN-1:0]    btn_prev_r;
   logic [N_BTN-1:0]    pending_r;
   logic [CODE_W-1:0]   mem_r [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_r;
   logic [PTR_W-1:0]    rd_ptr_r;
   logic [LVL_W-1:0]    level_r;
   logic                evt_valid_r;
   logic [CODE_W-1:0]   evt_code_r;
   logic                overflow_r;
   logic [N_BTN-1:0]    last_r;

   logic [N_BTN-1:0]    rise_s;
   logic [N_BTN-1:0]    cand_s;
   logic [CODE_W-1:0]   sel_s;
   logic                pop_s;
   logic                push_s;
   logic                ovf_set_s;
   logic [N_BTN-1:0]    pending_nxt_s;
   logic [PTR_W-1:0]    rd_nxt_s;
   logic [LVL_W-1:0]    level_nxt_s;
   logic [CODE_W-1:0]   code_nxt_s;

   // Edge detection, arbitration and push/pop decisions.
   always_comb begin
      rise_s        = '0;
      cand_s        = '0;
      sel_s         = '0;
      pop_s         = 1'b0;
      push_s        = 1'b0;
      ovf_set_s     = 1'b0;
      pending_nxt_s = '0;
      // Buttons already held when leaving reset are absorbed in ARM.
      if (state_r == ST_RUN) begin
         rise_s = btn_i & ~btn_prev_r;
      end else begin
         rise_s = '0;
      end
      cand_s    = pending_r | rise_s;
      sel_s     = lowest_idx(cand_s);
      pop_s     = evt_valid_r && evt_ready_i;
      push_s    = (cand_s != '0) && ((level_r < DEPTH_LVL) || pop_s);
      ovf_set_s = |(rise_s & pending_r);
      if (push_s) begin
         pending_nxt_s = cand_s & ~one_hot(sel_s);
      end else begin
         pending_nxt_s = cand_s;
      end
   end

   // Next read pointer, fill level and head code, so the outputs stay registered.
   always_comb begin
      rd_nxt_s    = rd_ptr_r;
      level_nxt_s = level_r;
      code_nxt_s  = '0;
      if (pop_s) begin
         rd_nxt_s = rd_ptr_r + PTR_W'(1);
      end else begin
         rd_nxt_s = rd_ptr_r;
      end
      if (push_s && !pop_s) begin
         level_nxt_s = level_r + LVL_W'(1);
      end else if (pop_s && !push_s) begin
         level_nxt_s = level_r - LVL_W'(1);
      end else begin
         level_nxt_s = level_r;
      end
      // A lone remaining entry that is being written this cycle is not in mem_r yet.
      if (level_nxt_s == LVL_W'(0)) begin
         code_nxt_s = '0;
      end else if (push_s && (level_nxt_s == LVL_W'(1))) begin
         code_nxt_s = sel_s;
      end else begin
         code_nxt_s = mem_r[rd_nxt_s];
      end
   end

   // FSM, FIFO storage and all registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_ARM;
         btn_prev_r  <= '0;
         pending_r   <= '0;
         wr_ptr_r    <= '0;
         rd_ptr_r    <= '0;
         level_r     <= '0;
         evt_valid_r <= 1'b0;
         evt_code_r  <= '0;
         overflow_r  <= 1'b0;
         last_r      <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else begin
         case (state_r)
            ST_ARM:  state_r <= ST_RUN;
            ST_RUN:  state_r <= ST_RUN;
            default: state_r <= ST_ARM;
         endcase
         btn_prev_r <= btn_i;
         pending_r  <= pending_nxt_s;
         if (push_s) begin
            mem_r[wr_ptr_r] <= sel_s;
            wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            last_r <= one_hot(evt_code_r);
         end
         rd_ptr_r    <= rd_nxt_s;
         level_r     <= level_nxt_s;
         evt_valid_r <= (level_nxt_s != LVL_W'(0));
         evt_code_r  <= code_nxt_s;
         if (ovf_set_s) begin
            overflow_r <= 1'b1;
         end else if (clr_ovf_i) begin
            overflow_r <= 1'b0;
         end
      end
   end

   assign evt_valid_o = evt_valid_r;
   assign evt_code_o  = evt_code_r;
   assign level_o     = level_r;
   assign overflow_o  = overflow_r;
   assign last_o      = last_r;

endmodule
